// File: rtl/clk_div_selector_pkg.sv
// clk_div_selector_pkg: shared FSM states, source-select encodings and the source mux helper
package clk_div_selector_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ARM} state_e;
  localparam logic [1:0] SEL_BY2 = 2'd0;
  localparam logic [1:0] SEL_BY4 = 2'd1;
  localparam logic [1:0] SEL_BY8 = 2'd2;
  localparam logic [1:0] SEL_OFF = 2'd3;
  function automatic logic src_pick(input logic [2:0] src, input logic [1:0] sel);
    return sel == SEL_BY2 ? src[0] : sel == SEL_BY4 ? src[1] : sel == SEL_BY8 ? src[2] : 1'b0;
  endfunction
endpackage

// File: rtl/clk_div_selector_if.sv
// clk_div_selector_if: divided-clock inputs, select request/ack and clock outputs of the selector
interface clk_div_selector_if #(parameter int CNT_W = 8);
  logic enable, clkby2, clkby4, clkby8, sel_req, sel_ack, clk_out, rise_tick, busy;
  logic [1:0] sel;
  logic [CNT_W-1:0] edge_count;
  modport master (
    output enable, clkby2, clkby4, clkby8, sel, sel_req,
    input sel_ack, clk_out, rise_tick, edge_count, busy
  );
  modport slave (
    input enable, clkby2, clkby4, clkby8, sel, sel_req,
    output sel_ack, clk_out, rise_tick, edge_count, busy
  );
endinterface

// File: rtl/clk_div_selector_edge_strobe.sv
// edge_strobe: registered rising-edge detector, strobe lands the cycle after d rises
module edge_strobe (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic d_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      d_q <= 1'b0;
      rise <= 1'b0;
    end else begin
      d_q <= d;
      rise <= d & ~d_q;
    end
endmodule

// File: rtl/clk_div_selector.sv
// clk_div_selector: glitch-free switch between divided clocks with request/ack handshake
module clk_div_selector
  import clk_div_selector_pkg::*;
#(parameter int CNT_W = 8) (
  input logic clock,
  input logic reset,
  clk_div_selector_if.slave bus
);
  state_e state;
  logic [1:0] cur_sel, next_sel;
  logic [2:0] src_q;
  logic clk_out, sel_ack, rise_tick, s, arm_done;
  logic [CNT_W-1:0] edge_count;
  assign s = src_pick(src_q, cur_sel);
  assign arm_done = state == ARM && bus.enable && !s;
  // DRAIN may only hold a high phase to its natural end, never start a new one
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cur_sel <= SEL_BY2;
      next_sel <= SEL_BY2;
      src_q <= '0;
      clk_out <= 1'b0;
      sel_ack <= 1'b0;
    end else begin
      src_q <= {bus.clkby8, bus.clkby4, bus.clkby2};
      sel_ack <= 1'b0;
      case (state)
        IDLE: begin
          clk_out <= 1'b0;
          if (bus.enable) begin
            cur_sel <= bus.sel;
            state <= ARM;
          end
        end
        RUN: begin
          clk_out <= s;
          if (!bus.enable) begin
            next_sel <= cur_sel;
            state <= DRAIN;
          end else if (bus.sel_req && bus.sel != cur_sel) begin
            next_sel <= bus.sel;
            state <= DRAIN;
          end else if (bus.sel_req && !sel_ack) sel_ack <= 1'b1;
        end
        DRAIN: begin
          clk_out <= clk_out & s;
          if (!s) begin
            cur_sel <= next_sel;
            state <= bus.enable ? ARM : IDLE;
          end
        end
        ARM: begin
          clk_out <= 1'b0;
          if (!bus.enable) begin
            next_sel <= cur_sel;
            state <= DRAIN;
          end else if (arm_done) begin
            state <= RUN;
            sel_ack <= 1'b1;
          end
        end
      endcase
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) edge_count <= '0;
    else edge_count <= arm_done ? '0 : edge_count + CNT_W'(rise_tick);
  edge_strobe u_strobe (.clock(clock), .reset(reset), .d(clk_out), .rise(rise_tick));
  assign bus.clk_out = clk_out;
  assign bus.sel_ack = sel_ack;
  assign bus.rise_tick = rise_tick;
  assign bus.edge_count = edge_count;
  assign bus.busy = state != RUN;
endmodule

// File: tb/tb_clk_div_selector.sv
// tb_clk_div_selector: directed and random select traffic checked against a cycle-level behavioural model
module tb_clk_div_selector;
  logic clock = 1'b0, reset = 1'b0, div_rst = 1'b0;
  logic [2:0] dcnt;
  int err_n = 0, chk_n = 0;
  clk_div_selector_if #(.CNT_W(8)) bus ();
  clk_div_selector_if #(.CNT_W(4)) bus4 ();
  clk_div_selector #(.CNT_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));
  clk_div_selector #(.CNT_W(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));
  always #5 clock = ~clock;
  always @(posedge clock) dcnt <= div_rst ? dcnt + 3'd1 : 3'd0;
  assign bus.clkby2 = dcnt[0];
  assign bus.clkby4 = dcnt[1];
  assign bus.clkby8 = dcnt[2];
  assign bus4.clkby2 = dcnt[0];
  assign bus4.clkby4 = dcnt[1];
  assign bus4.clkby8 = dcnt[2];
  assign bus4.enable = bus.enable;
  assign bus4.sel = bus.sel;
  assign bus4.sel_req = bus.sel_req;
  // model state: live selection, outstanding request token, output history
  logic [1:0] live = 2'd0, prev_live = 2'd0, req_sel = 2'd0;
  logic pend_same = 1'b0, busy_seen = 1'b0;
  int req_id = 0, served = 0, ec_m = 0, ph_len = 0, last_high = 0, rt_seen = 0, cyc = 0;
  logic [2:0] dh1 = 3'd0, dh2 = 3'd0;
  logic c1 = 1'b0, c2 = 1'b0, b1 = 1'b1, rt_prev = 1'b0, ph_lvl = 1'b0;
  function automatic logic src_of(input logic [2:0] d, input logic [1:0] s);
    int i;
    i = int'(s);
    return s == 2'd3 ? 1'b0 : d[i];
  endfunction
  function automatic int half(input logic [1:0] s);
    return s == 2'd3 ? 8 : 1 << s;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_n++;
    assert (got === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    logic clr;
    repeat (n) begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        c1 = 1'b0; c2 = 1'b0; b1 = 1'b1; rt_prev = 1'b0; ec_m = 0;
        ph_len = 0; ph_lvl = 1'b0; served = req_id;
      end else begin
        clr = 1'b0;
        if (bus.sel_ack) begin
          check("ack_expected", 32'(served != req_id), 1);
          if (served != req_id) begin
            clr = !pend_same;
            if (!pend_same) prev_live = live;
            live = req_sel;
            served = req_id;
          end
        end
        if (!b1) check("clk_follow", bus.clk_out, src_of(dh2, live));
        else check("no_rise_busy", bus.clk_out & ~c1, 0);
        check("rise_tick", bus.rise_tick, c1 & ~c2);
        ec_m = clr ? 0 : (ec_m + int'(rt_prev)) % 256;
        check("edge_count", bus.edge_count, ec_m);
        check("edge_count4", bus4.edge_count, ec_m % 16);
        if (bus.clk_out !== ph_lvl) begin
          check("phase_min", 32'(ph_len >= (half(live) < half(prev_live) ? half(live) : half(prev_live))), 1);
          if (ph_lvl) last_high = ph_len;
          ph_lvl = bus.clk_out;
          ph_len = 1;
        end else ph_len++;
        rt_seen += int'(bus.rise_tick);
        busy_seen |= bus.busy;
        rt_prev = c1 & ~c2;
        c2 = c1;
        c1 = bus.clk_out;
        b1 = bus.busy;
      end
      dh2 = dh1;
      dh1 = dcnt;
    end
  endtask
  task automatic wait_ack(output int waited);
    waited = 0;
    while (served != req_id && waited < 100) begin
      step(1);
      waited++;
    end
    check("ack_timeout", 32'(served == req_id), 1);
  endtask
  task automatic request(input logic [1:0] s, output int waited);
    req_sel = s;
    pend_same = s == live;
    req_id++;
    bus.sel = s;
    bus.sel_req = 1'b1;
    wait_ack(waited);
    bus.sel_req = 1'b0;
  endtask
  task automatic wait_rise();
    int b;
    b = 0;
    do begin step(1); b++; end while (!(c1 && !c2) && b < 40);
    check("rise_timeout", 32'(c1 && !c2), 1);
  endtask
  initial begin
    int w, t1;
    bus.enable = 1'b1;
    bus.sel = 2'd0;
    bus.sel_req = 1'b0;
    @(negedge clock);
    check("rst_clk_out", bus.clk_out, 0);
    check("rst_sel_ack", bus.sel_ack, 0);
    check("rst_rise_tick", bus.rise_tick, 0);
    check("rst_edge_count", bus.edge_count, 0);
    check("rst_busy", bus.busy, 1);
    #5 div_rst = 1'b1;
    step(1);
    req_sel = 2'd0;
    pend_same = 1'b0;
    req_id++;
    reset = 1'b1;
    wait_ack(w);
    step(2);
    rt_seen = 0;
    step(40);
    check("by2_rise_ticks", rt_seen, 20);
    check("by2_edge_count", bus.edge_count, 20);
    check("by2_edge_count_w4", bus4.edge_count, 4);
    w = 0;
    while (dcnt[0] !== 1'b0 && w < 4) begin step(1); w++; end
    busy_seen = 1'b0;
    request(2'd2, w);
    check("switch_busy_seen", busy_seen, 1);
    check("switch_ec_cleared", bus.edge_count, 0);
    check("switch_busy_after", bus.busy, 0);
    step(1);
    check("switch_ack_single", bus.sel_ack, 0);
    busy_seen = 1'b0;
    request(2'd2, w);
    check("same_ack_latency", w, 1);
    check("same_busy_seen", busy_seen, 0);
    request(2'd3, w);
    step(20);
    check("off_clk_low", bus.clk_out, 0);
    request(2'd1, w);
    wait_rise();
    t1 = cyc;
    wait_rise();
    check("by4_period", cyc - t1, 4);
    repeat (12) begin
      step($urandom_range(0, 15));
      request(2'($urandom_range(0, 3)), w);
    end
    request(2'd2, w);
    wait_rise();
    step(1);
    bus.enable = 1'b0;
    w = 0;
    while (bus.clk_out && w < 10) begin step(1); w++; end
    step(4);
    check("drain_high_len", last_high, 4);
    check("drain_idle_busy", bus.busy, 1);
    check("drain_idle_clk", bus.clk_out, 0);
    w = 0;
    while (dcnt !== 3'b100 && w < 20) begin step(1); w++; end
    req_sel = 2'd2;
    pend_same = 1'b0;
    req_id++;
    bus.enable = 1'b1;
    step(2);
    check("arm_busy", bus.busy, 1);
    reset = 1'b0;
    bus.enable = 1'b0;
    #1;
    check("arst_clk_out", bus.clk_out, 0);
    check("arst_sel_ack", bus.sel_ack, 0);
    check("arst_rise_tick", bus.rise_tick, 0);
    check("arst_edge_count", bus.edge_count, 0);
    check("arst_busy", bus.busy, 1);
    step(1);
    reset = 1'b1;
    step(8);
    check("post_rst_busy", bus.busy, 1);
    check("post_rst_clk", bus.clk_out, 0);
    check("post_rst_ec", bus.edge_count, 0);
    check("post_rst_ack", bus.sel_ack, 0);
    $display("Result: errors=%0d of %0d checks", err_n, chk_n);
    $finish;
  end
endmodule
